// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ifu_fetch_ctrl: sequences IFU fetch (AXI4 AR/R, IDU valid/ready, WBU commit) and drives PC/inst register enables.
// Revision: 1.0
module ifu_fetch_ctrl #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [1:0]  rresp_i,
  output logic        rdata_we_o,
  output logic        pc_we_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        wb_valid_i,
  output logic        fetch_err_o,
  output logic        timeout_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AR      = 3'd1,
    S_R       = 3'd2,
    S_VALID   = 3'd3,
    S_WAIT_WB = 3'd4
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              waiting;
  logic              wb_pending;

  assign wait_inc = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);

  always_comb begin
    state_nxt  = state;
    arvalid_o  = 1'b0;
    rready_o   = 1'b0;
    rdata_we_o = 1'b0;
    valid_o    = 1'b0;
    pc_we_o    = 1'b0;
    waiting    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_AR;
      S_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_nxt = S_R;
        else           waiting   = 1'b1;
      end
      S_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rdata_we_o = 1'b1;
          state_nxt  = S_VALID;
        end else begin
          waiting = 1'b1;
        end
      end
      S_VALID: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = S_WAIT_WB;
      end
      S_WAIT_WB: begin
        // A pending early commit and a live pulse in the same cycle still yield one PC write
        if (wb_valid_i || wb_pending) begin
          pc_we_o   = 1'b1;
          state_nxt = S_AR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      wb_pending  <= 1'b0;
      fetch_err_o <= 1'b0;
      timeout_o   <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_inc;

      if (waiting && (wait_inc == WAIT_LIMIT)) timeout_o <= 1'b1;

      if (pc_we_o)                                wb_pending <= 1'b0;
      else if (wb_valid_i && state != S_WAIT_WB)  wb_pending <= 1'b1;

      if (rdata_we_o) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
        if (rresp_i != 2'b00) fetch_err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
